sga_sonar_scheduler: RTL and testbench
======================================

# sga_sonar_scheduler

Measurement scheduler for the two HC-SR04 ultrasonic sensors that steer the snake. On each `medir` request from the game control unit, it runs one left-then-right measurement round. The two sensors are never active at the same time, and a guard interval separates them to prevent acoustic crosstalk. It classifies each echo as near or far and publishes the registered `esq`/`dir` direction bits consumed by the SGA control unit. It replaces the free-running per-sensor interfaces inside the game datapath.

## Interface
Parameters:
- `TRIG_CYCLES`, 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1500000: maximum wait for the echo rising edge, and maximum echo width (30 ms).
- `GUARD_CYCLES`, 3000000: dead time after each sensor's measurement (60 ms).
- `THRESH_CYCLES`, 29000: echo width strictly below this value means "near" (about 10 cm).

Ports:
- `clock` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `medir` in 1: request one measurement round. Sampled only in IDLE.
- `echo_esq`, `echo_dir` in 1: raw sensor echoes. Each is synchronized with 2 flops inside the block.
- `trigger_esq`, `trigger_dir` out 1: registered sensor triggers.
- `esq`, `dir` out 1: registered direction decision. Held between rounds.
- `pronto` out 1: one-cycle pulse when the round completes.
- `timeout_esq`, `timeout_dir` out 1: sticky per-round flags. Cleared when a new round starts.
- `db_state` out 4: current state encoding, for HEX display.

## Operation
- States and encodings: IDLE 0, TRIG_E 1, RISE_E 2, MEAS_E 3, GUARD_E 4, TRIG_D 5, RISE_D 6, MEAS_D 7, GUARD_D 8, DECIDE 9, DONE A.
- IDLE → TRIG_E when `medir`=1. On this transition, clear both timeout flags and the cycle counter.
- TRIG_x: `trigger_x` is high for exactly TRIG_CYCLES clocks, then the FSM goes to RISE_x.
- RISE_x: wait for a rising edge on the synchronized echo. An echo already high on entry does not count; a low→high transition is required.
  - On the edge → MEAS_x.
  - At TIMEOUT_CYCLES → GUARD_x. Set `timeout_x` and record the sensor as far.
- MEAS_x: count clocks while the echo is high.
  - On echo fall: near_x = (count < THRESH_CYCLES).
  - At TIMEOUT_CYCLES → GUARD_x. Set `timeout_x`, record the sensor as far, and saturate the count.
- GUARD_x: wait GUARD_CYCLES. GUARD_E → TRIG_D; GUARD_D → DECIDE.
- DECIDE: decide the direction from the near bits:
  - (near_e, near_d) = (1,0) → `esq`=1, `dir`=0.
  - (0,1) → `esq`=0, `dir`=1.
  - (0,0) or (1,1) → both 0.
- DONE: `pronto`=1 for one cycle, then IDLE.
- `medir` outside IDLE is ignored. It is not queued.
- One shared counter, width $clog2 of the largest parameter plus 1, reset to 0 on every state change.
- Echo activity outside the RISE/MEAS states of its own sensor is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, near bits 0, synchronizers 0.
- Asserting `reset` mid-round aborts immediately. Triggers drop asynchronously.
- `trigger_esq` rises the cycle after `medir` is sampled in IDLE.
- The echo synchronizer adds 2 cycles, plus 1 cycle for edge detection.
- `esq`/`dir` update on the clock edge leaving DECIDE. `pronto` is high in the following cycle.
- Round latency = 2·TRIG + 2·GUARD + rise wait + echo width + sync overhead + 3 clocks.
- `trigger_esq` and `trigger_dir` are never high simultaneously, under any input.

## Configuration
- `SONAR_HYST_EN` defined: DECIDE commits a new `esq`/`dir` value only if the decision computed this round equals the decision computed in the previous round. This needs one extra 2-bit register, which resets to 00. Otherwise the outputs hold their old values. `pronto` still pulses every round.
- `SONAR_HYST_EN` undefined: every round's decision is committed directly.

## Test plan
Use bench parameters TRIG=4, TIMEOUT=100, GUARD=8, THRESH=20.
- Reset, then `medir` pulse. Left echo is 10 clocks wide, right echo is 50 clocks wide → `esq`=1, `dir`=0, one `pronto` pulse, no timeout flags.
- Left echo 50 clocks, right echo 10 clocks → `dir`=1, `esq`=0. Both echoes 10 clocks → both 0.
- Right echo never rises → `timeout_dir`=1 after 100 clocks in RISE_D. Right is treated as far. Round completes and returns to IDLE.
- Left echo held high for 150 clocks → MEAS_E saturates at 100 and `timeout_esq`=1. Check on every cycle that `trigger_dir` never overlaps `trigger_esq`.
- `medir` re-pulsed during MEAS_E, and `reset` asserted during GUARD_D → extra request ignored. Reset forces all outputs to 0 and the FSM to IDLE immediately.
- With `SONAR_HYST_EN`: rounds giving left, then right, then right → `esq`/`dir` stay 00 after round 1 (no previous match), stay 00 after round 2, and become `dir`=1 after round 3.

Source files
------------

// File: rtl/sga_sonar_scheduler.sv
// sga_sonar_scheduler: one left-then-right HC-SR04 round per medir request, classifying each echo to drive esq/dir.
// Latency: 2*TRIG + 2*GUARD + rise waits + echo widths + sync overhead + 3 clocks; pronto pulses once per round.
// No backpressure: medir is only sampled in IDLE and never queued. Macro SONAR_HYST_EN commits only repeated decisions.
module sga_sonar_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GUARD_CYCLES   = 3000000,
    parameter int THRESH_CYCLES  = 29000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       medir,
    input  logic       echo_esq,
    input  logic       echo_dir,
    output logic       trigger_esq,
    output logic       trigger_dir,
    output logic       esq,
    output logic       dir,
    output logic       pronto,
    output logic       timeout_esq,
    output logic       timeout_dir,
    output logic [3:0] db_state
);

    localparam int MAX_AB = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CD = (GUARD_CYCLES > THRESH_CYCLES) ? GUARD_CYCLES : THRESH_CYCLES;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] TRIG_M1    = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_M1   = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] THRESH_M1  = CW'(THRESH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    typedef enum logic [3:0] {
        IDLE    = 4'h0,
        TRIG_E  = 4'h1,
        RISE_E  = 4'h2,
        MEAS_E  = 4'h3,
        GUARD_E = 4'h4,
        TRIG_D  = 4'h5,
        RISE_D  = 4'h6,
        MEAS_D  = 4'h7,
        GUARD_D = 4'h8,
        DECIDE  = 4'h9,
        DONE    = 4'hA
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            near_e_q, near_e_d, near_d_q, near_d_d;
    logic            to_e_q, to_e_d, to_d_q, to_d_d;
    logic            esq_q, esq_d, dir_q, dir_d;
    logic            trig_e_q, trig_d_q, pronto_q;
    logic            esq_s1_q, esq_s2_q, esq_prev_q;
    logic            dir_s1_q, dir_s2_q, dir_prev_q;
    logic            is_dir, echo_s, echo_rise, meas_near;
    logic            set_to, set_near;
    logic [1:0]      dec;
    state_t          guard_st;
`ifdef SONAR_HYST_EN
    logic [1:0]      dec_prev_q, dec_prev_d;
`endif

    // Only the sensor owning the current RISE/MEAS state is looked at; the other echo is ignored.
    assign is_dir    = (state_q == RISE_D) || (state_q == MEAS_D);
    assign guard_st  = is_dir ? GUARD_D : GUARD_E;
    assign echo_s    = is_dir ? dir_s2_q : esq_s2_q;
    assign echo_rise = echo_s & ~(is_dir ? dir_prev_q : esq_prev_q);
    // The edge cycle is spent in RISE, so the echo width seen at the fall is cnt+1.
    assign meas_near = (cnt_q < THRESH_M1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        near_e_d = near_e_q;
        near_d_d = near_d_q;
        to_e_d   = to_e_q;
        to_d_d   = to_d_q;
        esq_d    = esq_q;
        dir_d    = dir_q;
        set_to   = 1'b0;
        set_near = 1'b0;
        dec      = {near_e_q & ~near_d_q, ~near_e_q & near_d_q};
`ifdef SONAR_HYST_EN
        dec_prev_d = dec_prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (medir) begin
                    state_d = TRIG_E;
                    to_e_d  = 1'b0;
                    to_d_d  = 1'b0;
                end
            end
            TRIG_E:  if (cnt_q == TRIG_M1) state_d = RISE_E;
            TRIG_D:  if (cnt_q == TRIG_M1) state_d = RISE_D;
            RISE_E, RISE_D: begin
                if (echo_rise) begin
                    state_d = is_dir ? MEAS_D : MEAS_E;
                end else if (cnt_q == TIMEOUT_M1) begin
                    state_d = guard_st;
                    set_to  = 1'b1;
                end
            end
            MEAS_E, MEAS_D: begin
                if (!echo_s) begin
                    state_d  = guard_st;
                    set_near = 1'b1;
                end else if (cnt_q == TIMEOUT_M1) begin
                    state_d = guard_st;
                    set_to  = 1'b1;
                end
            end
            GUARD_E: if (cnt_q == GUARD_M1) state_d = TRIG_D;
            GUARD_D: if (cnt_q == GUARD_M1) state_d = DECIDE;
            DECIDE: begin
                state_d = DONE;
`ifdef SONAR_HYST_EN
                dec_prev_d = dec;
                if (dec == dec_prev_q) {esq_d, dir_d} = dec;
`else
                {esq_d, dir_d} = dec;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A timeout always records the sensor as far.
        if (set_to || set_near) begin
            if (is_dir) begin
                to_d_d   = to_d_q | set_to;
                near_d_d = set_near & meas_near;
            end else begin
                to_e_d   = to_e_q | set_to;
                near_e_d = set_near & meas_near;
            end
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            esq_s1_q   <= 1'b0;
            esq_s2_q   <= 1'b0;
            esq_prev_q <= 1'b0;
            dir_s1_q   <= 1'b0;
            dir_s2_q   <= 1'b0;
            dir_prev_q <= 1'b0;
        end else begin
            esq_s1_q   <= echo_esq;
            esq_s2_q   <= esq_s1_q;
            esq_prev_q <= esq_s2_q;
            dir_s1_q   <= echo_dir;
            dir_s2_q   <= dir_s1_q;
            dir_prev_q <= dir_s2_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            near_e_q <= 1'b0;
            near_d_q <= 1'b0;
            to_e_q   <= 1'b0;
            to_d_q   <= 1'b0;
            esq_q    <= 1'b0;
            dir_q    <= 1'b0;
            trig_e_q <= 1'b0;
            trig_d_q <= 1'b0;
            pronto_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            near_e_q <= near_e_d;
            near_d_q <= near_d_d;
            to_e_q   <= to_e_d;
            to_d_q   <= to_d_d;
            esq_q    <= esq_d;
            dir_q    <= dir_d;
            // Triggers follow the next state, so they are exclusive by construction.
            trig_e_q <= (state_d == TRIG_E);
            trig_d_q <= (state_d == TRIG_D);
            pronto_q <= (state_d == DONE);
        end
    end

`ifdef SONAR_HYST_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) dec_prev_q <= 2'b00;
        else        dec_prev_q <= dec_prev_d;
    end
`endif

    assign trigger_esq = trig_e_q;
    assign trigger_dir = trig_d_q;
    assign esq         = esq_q;
    assign dir         = dir_q;
    assign pronto      = pronto_q;
    assign timeout_esq = to_e_q;
    assign timeout_dir = to_d_q;
    assign db_state    = state_q;

endmodule

// File: tb/tb_sga_sonar_scheduler.sv
// Bench for sga_sonar_scheduler: a round-level timing model predicts triggers, pronto, flags and decisions each cycle.
module tb_sga_sonar_scheduler;

    localparam int TRIG = 4;
    localparam int TO   = 100;
    localparam int GRD  = 8;
    localparam int TH   = 20;

    logic       clock = 1'b0;
    logic       reset, medir, echo_esq, echo_dir;
    logic       trigger_esq, trigger_dir, esq, dir, pronto, timeout_esq, timeout_dir;
    logic [3:0] db_state;

    sga_sonar_scheduler #(
        .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GRD), .THRESH_CYCLES(TH)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir),
        .echo_esq(echo_esq), .echo_dir(echo_dir),
        .trigger_esq(trigger_esq), .trigger_dir(trigger_dir),
        .esq(esq), .dir(dir), .pronto(pronto),
        .timeout_esq(timeout_esq), .timeout_dir(timeout_dir),
        .db_state(db_state)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state: edge numbers after which events are expected.
    int t_e0 = -1000, t_d0 = -1000, t_pr = -1000;
    int te_at = -1, td_at = -1;
    int e_start = 0, e_w = 0, d_start = 0, d_w = 0;
    bit rnd_esq = 0, rnd_dir = 0, cur_esq = 0, cur_dir = 0;
    bit [1:0] last_dec = 2'b00;
    bit chk_en = 0;
    int last_pr = -1, tod_rise = -1;
    bit tod_prev = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from a sensor's trigger start to its guard entry; w==0 means the echo never rises.
    function automatic void sensor(input int d, input int w, output int len, output int to_off,
                                   output bit near);
        if (w == 0) begin
            len = TRIG + TO; to_off = TRIG + TO; near = 1'b0;
        end else if (w > TO) begin
            len = TRIG + 3 + d + TO; to_off = len; near = 1'b0;
        end else begin
            len = TRIG + 3 + d + w; to_off = -1; near = (w < TH);
        end
    endfunction

    task automatic wait_until(input int target);
        if (target - cyc > 5000) begin
            failures++;
            $display("FAIL wait_bound: target %0d unreachable from cycle %0d", target, cyc);
        end else begin
            while (cyc < target) @(negedge clock);
        end
    endtask

    // Echo driver: raw echoes follow the scheduled windows.
    initial begin
        echo_esq = 1'b0;
        echo_dir = 1'b0;
        forever begin
            @(negedge clock);
            echo_esq = (e_w > 0) && (cyc >= e_start) && (cyc < e_start + e_w);
            echo_dir = (d_w > 0) && (cyc >= d_start) && (cyc < d_start + d_w);
        end
    end

    // Compare process.
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                if (cyc == t_pr) begin
                    cur_esq = rnd_esq;
                    cur_dir = rnd_dir;
                end
                chk1("trigger_esq", trigger_esq, (cyc >= t_e0) && (cyc < t_e0 + TRIG));
                chk1("trigger_dir", trigger_dir, (cyc >= t_d0) && (cyc < t_d0 + TRIG));
                chk1("trigger_overlap", trigger_esq & trigger_dir, 1'b0);
                chk1("pronto", pronto, cyc == t_pr);
                chk1("esq", esq, cur_esq);
                chk1("dir", dir, cur_dir);
                if (cyc >= t_e0) begin
                    chk1("timeout_esq", timeout_esq, (te_at >= 0) && (cyc >= te_at));
                    chk1("timeout_dir", timeout_dir, (td_at >= 0) && (cyc >= td_at));
                end
                if (cyc == t_e0)     chk4("state_trig_e", db_state, 4'h1);
                if (cyc == t_d0)     chk4("state_trig_d", db_state, 4'h5);
                if (cyc == t_pr - 1) chk4("state_decide", db_state, 4'h9);
                if (cyc == t_pr)     chk4("state_done", db_state, 4'hA);
                if (cyc == t_pr + 1) chk4("state_idle", db_state, 4'h0);
                if (pronto === 1'b1) last_pr = cyc;
                if (timeout_dir === 1'b1 && !tod_prev) tod_rise = cyc;
                tod_prev = (timeout_dir === 1'b1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk1({tag, "_trigger_esq"}, trigger_esq, 1'b0);
        chk1({tag, "_trigger_dir"}, trigger_dir, 1'b0);
        chk1({tag, "_esq"}, esq, 1'b0);
        chk1({tag, "_dir"}, dir, 1'b0);
        chk1({tag, "_pronto"}, pronto, 1'b0);
        chk1({tag, "_timeout_esq"}, timeout_esq, 1'b0);
        chk1({tag, "_timeout_dir"}, timeout_dir, 1'b0);
        chk4({tag, "_db_state"}, db_state, 4'h0);
    endtask

    task automatic run_round(input int de, input int we, input int dd, input int wd,
                             input bit extra, input bit abort);
        int n0, len_e, len_d, to_e, to_d;
        bit n_e, n_d;
        bit [1:0] dec;
        n0 = cyc + 1;
        sensor(de, we, len_e, to_e, n_e);
        sensor(dd, wd, len_d, to_d, n_d);
        t_e0 = n0;
        t_d0 = n0 + len_e + GRD;
        t_pr = t_d0 + len_d + GRD + 1;
        te_at = (to_e < 0) ? -1 : n0 + to_e;
        td_at = (to_d < 0) ? -1 : t_d0 + to_d;
        e_start = n0 + TRIG + de;  e_w = we;
        d_start = t_d0 + TRIG + dd; d_w = wd;
        dec = {n_e & ~n_d, ~n_e & n_d};
`ifdef SONAR_HYST_EN
        if (dec == last_dec) {rnd_esq, rnd_dir} = dec;
        else                 {rnd_esq, rnd_dir} = {cur_esq, cur_dir};
        last_dec = dec;
`else
        {rnd_esq, rnd_dir} = dec;
`endif
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
        if (extra) begin
            wait_until(n0 + TRIG + 1 + de + 4);
            medir = 1'b1;
            @(negedge clock);
            medir = 1'b0;
        end
        if (abort) begin
            wait_until(t_d0 + len_d + 2);
            chk4("pre_abort_state", db_state, 4'h8);
            chk_en = 1'b0;
            #2 reset = 1'b0;
            #1 check_all_zero("async_reset");
            cur_esq = 0; cur_dir = 0; last_dec = 2'b00;
            t_e0 = -1000; t_d0 = -1000; t_pr = -1000;
            te_at = -1; td_at = -1; e_w = 0; d_w = 0;
            @(negedge clock);
            check_all_zero("held_reset");
            reset = 1'b1;
            @(negedge clock);
            chk_en = 1'b1;
        end else begin
            wait_until(t_pr + 2);
        end
    endtask

    initial begin
        reset = 1'b0;
        medir = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("post_reset");
        chk_en = 1'b1;

        // L10/R50 -> left near: 27 + 67 + 1 cycles from medir sample to pronto.
        run_round(2, 10, 2, 50, 1'b0, 1'b0);
        chkn("round1_latency", last_pr - t_e0, 95);
`ifdef SONAR_HYST_EN
        chk1("round1_esq_literal", esq, 1'b0);
`else
        chk1("round1_esq_literal", esq, 1'b1);
`endif
        // L50/R10 with a stray medir during MEAS_E.
        run_round(1, 50, 3, 10, 1'b1, 1'b0);
        run_round(0, 10, 0, 10, 1'b0, 1'b0);
        // Right never rises: timeout_dir after 27 + 4 + 100 cycles.
        run_round(2, 10, 2, 0, 1'b0, 1'b0);
        chkn("rise_timeout_at", tod_rise - t_e0, 131);
        chk1("rise_timeout_literal", timeout_dir, 1'b1);
        chk4("back_to_idle", db_state, 4'h0);
        // Left echo held 150 clocks: MEAS_E saturates.
        run_round(2, 150, 1, 10, 1'b0, 1'b0);
        chk1("meas_timeout_literal", timeout_esq, 1'b1);
        // Stray medir in MEAS_E, then reset in GUARD_D.
        run_round(2, 10, 2, 50, 1'b1, 1'b1);
        // Left, right, right.
        run_round(2, 10, 2, 50, 1'b0, 1'b0);
        run_round(2, 50, 2, 10, 1'b0, 1'b0);
        run_round(2, 50, 2, 10, 1'b0, 1'b0);
        chk1("final_dir_literal", dir, 1'b1);
        chk1("final_esq_literal", esq, 1'b0);
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
